// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// rtl/nibble_serial_adder_ctrl_pkg.sv - shared FSM state type and slice width for the nibble-serial adder
package alu_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_ctrl_cla4.sv
// rtl/nibble_serial_adder_ctrl_cla4.sv - 4-bit carry lookahead adder slice
module CarryLookAheadAdder4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // Propagate/generate terms and fully expanded lookahead carries.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);
    sum   = p ^ c[3:0];
    c_out = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - WIDTH-bit add/subtract sequenced one nibble per clock through a shared CLA slice
module nibble_serial_adder_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / SLICE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;       // operand B already inverted for subtract
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   res_next;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  CarryLookAheadAdder4Bit u_slice (
    .a     (a_q[idx_q*SLICE_W +: SLICE_W]),
    .b     (b_q[idx_q*SLICE_W +: SLICE_W]),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  // Next-state and next-output logic; results are only published on the last RUN edge.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;

    res_next = res_q;
    res_next[idx_q*SLICE_W +: SLICE_W] = slice_sum;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = op_a;
          b_d        = op_b ^ {WIDTH{sub}};
          carry_d    = sub;
          idx_d      = '0;
          res_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        res_d   = res_next;
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          state_d     = DONE;
          sum_d       = res_next;
          c_out_d     = slice_cout;
          ovf_d       = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_sum[SLICE_W-1] ^ slice_cout;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - scoreboard bench for nibble_serial_adder_ctrl
module tb_nibble_serial_adder_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W:0] full;
    exp_t       e;
    full = {1'b0, a} + {1'b0, (s ? ~b : b)} + {{W{1'b0}}, s};
    e.s  = full[W-1:0];
    e.c  = full[W];
    if (s) e.v = (a[W-1] != b[W-1]) && (e.s[W-1] != a[W-1]);
    else   e.v = (a[W-1] == b[W-1]) && (e.s[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int bp, input bit inject);
    int         cyc;
    exp_t       e;
    logic [W-1:0] held;
    @(negedge clk);
    check_eq("in_ready_idle", in_ready, 1);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    sb.push_back(model(a, b, s));
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      check_eq("in_ready_run", in_ready, 0);
      if (inject && cyc == 1) begin
        op_a = 16'hAAAA; op_b = 16'h5555; sub = ~s; in_valid = 1'b1;
      end
      if (cyc == 2) in_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("latency", cyc, 4);
    if (!out_valid) return;
    held = sum;
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_sum_stable", sum, held);
    end
    e = sb.pop_front();
    check_eq("sum", sum, e.s);
    check_eq("c_out", c_out, e.c);
    check_eq("overflow", overflow, e.v);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("post_out_valid", out_valid, 0);
    check_eq("post_in_ready", in_ready, 1);
    check_eq("post_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_c_out", c_out, 0);
    check_eq("rst_overflow", overflow, 0);
    reset = 1'b0;

    run_op(16'h1234, 16'h0FFF, 1'b0, 3, 1'b1);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);

    // Reset after two RUN cycles.
    @(negedge clk);
    op_a = 16'h4444; op_b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_eq("rst_mid_out_valid", out_valid, 0);
    check_eq("rst_mid_sum", sum, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);

    check_eq("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
